// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared loader states, opcodes and default widths for the MIPS-32 slice
package mips_pkg;

  typedef enum logic [2:0] {
    LS_IDLE  = 3'd0,
    LS_CLEAR = 3'd1,
    LS_REGS  = 3'd2,
    LS_LOAD  = 3'd3,
    LS_START = 3'd4,
    LS_RUN   = 3'd5,
    LS_DONE  = 3'd6
  } ld_state_e;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_ADDI = 6'b001010;
  localparam logic [5:0] OP_HLT  = 6'b111111;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 32;

endpackage

// File: rtl/mips_prog_loader_if.sv
// rtl/mips_prog_loader_if.sv - program-load stream from the host/debug port into the loader
interface mips_prog_loader_if
  import mips_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic              ld_valid;
  logic              ld_ready;
  logic              ld_last;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;

  modport master (output ld_valid, ld_addr, ld_data, ld_last, input ld_ready);
  modport slave  (input ld_valid, ld_addr, ld_data, ld_last, output ld_ready);
endinterface

// File: rtl/mips_sat_counter.sv
// rtl/mips_sat_counter.sv - saturating up-counter with a look-ahead compare on the next value
module mips_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk1,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] cmp,
  output logic [CNT_W-1:0] count,
  output logic             hit
);
  logic [CNT_W-1:0] count_nxt;

  // hit compares the value the counter takes if enabled this cycle
  assign count_nxt = (&count) ? count : count + CNT_W'(1);
  assign hit       = (count_nxt == cmp);

  always_ff @(posedge clk1) begin
    if (rst || clear) count <= '0;
    else if (enable)  count <= count_nxt;
  end
endmodule

// File: rtl/mips_prog_loader.sv
// rtl/mips_prog_loader.sv - clears memory, seeds registers, loads a program and supervises a core run
module mips_prog_loader
  import mips_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = 32,
  parameter int CNT_W    = 32,
  parameter bit CLEAR_EN = 1'b1,
  parameter bit REG_INIT = 1'b1,
  localparam int RF_AW   = $clog2(NUM_REGS)
) (
  input  logic                clk1,
  input  logic                rst,
  input  logic                go,
  mips_prog_loader_if.slave   ld,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                rf_we,
  output logic [RF_AW-1:0]    rf_addr,
  output logic [DATA_W-1:0]   rf_wdata,
  output logic                cpu_hold,
  output logic                cpu_start,
  input  logic                cpu_halted,
  input  logic [CNT_W-1:0]    timeout_cycles,
  output logic                done,
  output logic                timed_out,
  output logic [CNT_W-1:0]    cycle_count
);
  localparam int SW = (ADDR_W > RF_AW) ? ADDR_W : RF_AW;

  localparam logic [2:0] S_IDLE  = LS_IDLE;
  localparam logic [2:0] S_CLEAR = LS_CLEAR;
  localparam logic [2:0] S_REGS  = LS_REGS;
  localparam logic [2:0] S_LOAD  = LS_LOAD;
  localparam logic [2:0] S_START = LS_START;
  localparam logic [2:0] S_RUN   = LS_RUN;
  localparam logic [2:0] S_DONE  = LS_DONE;

  logic [2:0]    state, state_nxt;
  logic [SW-1:0] sweep;
  logic          go_ok, hs, clear_last, regs_last, hit, tmo_hit;

  assign go_ok      = go && (state == S_IDLE || state == S_DONE);
  assign ld.ld_ready = (state == S_LOAD);
  assign hs         = ld.ld_valid && ld.ld_ready;
  assign clear_last = (sweep[ADDR_W-1:0] == {ADDR_W{1'b1}});
  assign regs_last  = (sweep == SW'(NUM_REGS - 1));
  assign tmo_hit    = (timeout_cycles != '0) && hit;

  assign cpu_start = (state == S_START);
  assign cpu_hold  = !(state == S_START || state == S_RUN);
  assign done      = (state == S_DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (go) state_nxt = CLEAR_EN ? S_CLEAR : S_REGS;
      S_CLEAR:        if (clear_last) state_nxt = S_REGS;
      S_REGS:         if (regs_last) state_nxt = S_LOAD;
      S_LOAD:         if (hs && ld.ld_last) state_nxt = S_START;
      S_START:        state_nxt = S_RUN;
      // a halt seen in the same cycle as the timeout match takes precedence
      S_RUN:          if (cpu_halted || tmo_hit) state_nxt = S_DONE;
      default:        state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk1) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // one sweep counter serves both the memory clear and the register seeding
  always_ff @(posedge clk1) begin
    if (rst || go_ok || (state == S_CLEAR && clear_last)) sweep <= '0;
    else if (state == S_CLEAR || state == S_REGS)         sweep <= sweep + SW'(1);
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rf_we     <= 1'b0;
      rf_addr   <= '0;
      rf_wdata  <= '0;
    end else begin
      mem_we <= (state == S_CLEAR) || hs;
      if (state == S_CLEAR) begin
        mem_addr  <= sweep[ADDR_W-1:0];
        mem_wdata <= '0;
      end else if (hs) begin
        mem_addr  <= ld.ld_addr;
        mem_wdata <= ld.ld_data;
      end
      rf_we <= (state == S_REGS);
      if (state == S_REGS) begin
        rf_addr  <= sweep[RF_AW-1:0];
        rf_wdata <= REG_INIT ? DATA_W'(sweep) : '0;
      end
    end
  end

  always_ff @(posedge clk1) begin
    if (rst || go_ok)                                 timed_out <= 1'b0;
    else if (state == S_RUN && !cpu_halted && tmo_hit) timed_out <= 1'b1;
  end

  mips_sat_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk1   (clk1),
    .rst    (rst),
    .clear  (go_ok || state == S_START),
    .enable (state == S_RUN && !cpu_halted),
    .cmp    (timeout_cycles),
    .count  (cycle_count),
    .hit    (hit)
  );
endmodule

// File: tb/tb_mips_prog_loader.sv
// tb/tb_mips_prog_loader.sv - directed-vector bench for mips_prog_loader
module tb_mips_prog_loader;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 32;

  logic              clk1 = 1'b0;
  logic              rst = 1'b1;
  logic              go = 1'b0;
  logic              mem_we, rf_we, cpu_hold, cpu_start, done, timed_out;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, rf_wdata;
  logic [4:0]        rf_addr;
  logic              cpu_halted = 1'b0;
  logic [CNT_W-1:0]  timeout_cycles = '0;
  logic [CNT_W-1:0]  cycle_count;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] prog [4];

  mips_prog_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ld_if ();

  mips_prog_loader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(32), .CNT_W(CNT_W),
    .CLEAR_EN(1'b1), .REG_INIT(1'b1)
  ) dut (
    .clk1(clk1), .rst(rst), .go(go), .ld(ld_if.slave),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
    .cpu_hold(cpu_hold), .cpu_start(cpu_start), .cpu_halted(cpu_halted),
    .timeout_cycles(timeout_cycles), .done(done), .timed_out(timed_out),
    .cycle_count(cycle_count)
  );

  always #5 clk1 = ~clk1;

  task automatic test_reset;
    @(negedge clk1);
    @(negedge clk1);
    vectors++;
    if ({cpu_hold, cpu_start, done, timed_out, mem_we, rf_we, ld_if.ld_ready} !== 7'b1000000) begin
      miscompares++;
      $display("FAIL reset_ctrl got %b want 1000000", {cpu_hold, cpu_start, done, timed_out, mem_we, rf_we, ld_if.ld_ready});
    end
    vectors++;
    if (cycle_count !== '0) begin
      miscompares++;
      $display("FAIL reset_count got %0d want 0", cycle_count);
    end
    rst = 1'b0;
  endtask

  task automatic test_clear_seed;
    go = 1'b1;
    for (int c = 1; c <= 49; c++) begin
      @(negedge clk1);
      go = 1'b0;
      vectors++;
      if (mem_we !== (c >= 2 && c <= 17)) begin
        miscompares++;
        $display("FAIL clear_we cyc %0d got %b", c, mem_we);
      end
      if (c >= 2 && c <= 17) begin
        vectors++;
        if (mem_addr !== 4'(c - 2) || mem_wdata !== 32'h0) begin
          miscompares++;
          $display("FAIL clear_wr cyc %0d got %h/%h want %h/0", c, mem_addr, mem_wdata, 4'(c - 2));
        end
      end
      vectors++;
      if (rf_we !== (c >= 18)) begin
        miscompares++;
        $display("FAIL seed_we cyc %0d got %b", c, rf_we);
      end
      if (c >= 18) begin
        vectors++;
        if (rf_addr !== 5'(c - 18) || rf_wdata !== 32'(c - 18)) begin
          miscompares++;
          $display("FAIL seed_wr cyc %0d got %h/%h want %0d", c, rf_addr, rf_wdata, c - 18);
        end
      end
      vectors++;
      if (ld_if.ld_ready !== (c == 49)) begin
        miscompares++;
        $display("FAIL ld_ready_rise cyc %0d got %b want %b", c, ld_if.ld_ready, c == 49);
      end
    end
  endtask

  task automatic test_load_gaps;
    timeout_cycles = 100;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin
        @(negedge clk1);
        vectors++;
        if (mem_we !== i[0]) begin
          miscompares++;
          $display("FAIL load_we step %0d got %b want %b", i, mem_we, i[0]);
        end
        if (i[0]) begin
          vectors++;
          if (mem_addr !== 4'((i - 1) / 2) || mem_wdata !== prog[(i - 1) / 2]) begin
            miscompares++;
            $display("FAIL load_wr step %0d got %h/%h want %h/%h", i, mem_addr, mem_wdata, 4'((i - 1) / 2), prog[(i - 1) / 2]);
          end
        end
        vectors++;
        if (cpu_start !== (i == 7)) begin
          miscompares++;
          $display("FAIL start_pulse step %0d got %b want %b", i, cpu_start, i == 7);
        end
      end
      ld_if.ld_valid = !i[0];
      ld_if.ld_addr  = 4'(i / 2);
      ld_if.ld_data  = prog[i / 2];
      ld_if.ld_last  = !i[0] && (i / 2 == 3);
    end
    @(negedge clk1);
    vectors++;
    if ({cpu_start, mem_we, cpu_hold} !== 3'b000) begin
      miscompares++;
      $display("FAIL run_entry got start/we/hold %b want 000", {cpu_start, mem_we, cpu_hold});
    end
  endtask

  task automatic do_run(input int halt_at, input int exp_cnt, input logic exp_to, input string nm);
    int k;
    for (k = 1; k <= 200; k++) begin
      if (k == halt_at) cpu_halted = 1'b1;
      @(negedge clk1);
      if (done) break;
    end
    cpu_halted = 1'b0;
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL %s_done got 0 want 1 within 200 cycles", nm);
    end
    vectors++;
    if ({timed_out, cpu_hold} !== {exp_to, 1'b1} || cycle_count !== CNT_W'(exp_cnt)) begin
      miscompares++;
      $display("FAIL %s_result got to=%b hold=%b cnt=%0d want to=%b hold=1 cnt=%0d", nm, timed_out, cpu_hold, cycle_count, exp_to, exp_cnt);
    end
  endtask

  task automatic prep_run(input int tmo);
    int n;
    timeout_cycles = CNT_W'(tmo);
    go = 1'b1;
    @(negedge clk1);
    go = 1'b0;
    vectors++;
    if ({done, timed_out} !== 2'b00 || cycle_count !== '0) begin
      miscompares++;
      $display("FAIL go_clears got done=%b to=%b cnt=%0d want 0/0/0", done, timed_out, cycle_count);
    end
    for (n = 0; n < 100 && !ld_if.ld_ready; n++) @(negedge clk1);
    ld_if.ld_valid = 1'b1;
    ld_if.ld_addr  = 4'd5;
    ld_if.ld_data  = 32'hFC000000;
    ld_if.ld_last  = 1'b1;
    @(negedge clk1);
    ld_if.ld_valid = 1'b0;
    ld_if.ld_last  = 1'b0;
    vectors++;
    if (cpu_start !== 1'b1) begin
      miscompares++;
      $display("FAIL prep_start got %b want 1", cpu_start);
    end
    @(negedge clk1);
  endtask

  task automatic test_halt;
    do_run(8, 7, 1'b0, "halt");
  endtask

  task automatic test_timeout;
    prep_run(20);
    do_run(0, 20, 1'b1, "timeout");
  endtask

  task automatic test_halt_vs_timeout;
    prep_run(20);
    do_run(20, 19, 1'b0, "tie");
  endtask

  task automatic test_back_to_back_reset;
    int n;
    go = 1'b1;
    @(negedge clk1);
    go = 1'b0;
    for (n = 0; n < 100 && !ld_if.ld_ready; n++) @(negedge clk1);
    for (int w = 0; w < 2; w++) begin
      ld_if.ld_valid = 1'b1;
      ld_if.ld_addr  = 4'(w);
      ld_if.ld_data  = prog[w];
      ld_if.ld_last  = 1'b0;
      @(negedge clk1);
    end
    ld_if.ld_valid = 1'b0;
    vectors++;
    if (mem_we !== 1'b1 || mem_addr !== 4'd1 || mem_wdata !== prog[1]) begin
      miscompares++;
      $display("FAIL b2b_second got we=%b %h/%h want 1 1/%h", mem_we, mem_addr, mem_wdata, prog[1]);
    end
    rst = 1'b1;
    @(negedge clk1);
    rst = 1'b0;
    vectors++;
    if ({cpu_hold, cpu_start, done, timed_out, mem_we, rf_we, ld_if.ld_ready} !== 7'b1000000) begin
      miscompares++;
      $display("FAIL midload_rst_ctrl got %b want 1000000", {cpu_hold, cpu_start, done, timed_out, mem_we, rf_we, ld_if.ld_ready});
    end
    vectors++;
    if (cycle_count !== '0 || mem_addr !== '0 || mem_wdata !== '0 || rf_addr !== '0 || rf_wdata !== '0) begin
      miscompares++;
      $display("FAIL midload_rst_data got cnt=%0d ma=%h md=%h ra=%h rd=%h want all 0", cycle_count, mem_addr, mem_wdata, rf_addr, rf_wdata);
    end
    go = 1'b1;
    @(negedge clk1);
    go = 1'b0;
    @(negedge clk1);
    vectors++;
    if (mem_we !== 1'b1 || mem_addr !== 4'd0) begin
      miscompares++;
      $display("FAIL restart_clear got we=%b addr=%h want 1/0", mem_we, mem_addr);
    end
  endtask

  initial begin
    prog[0] = 32'h00430800;
    prog[1] = 32'h2824000A;
    prog[2] = 32'h20232800;
    prog[3] = 32'hFC000000;
    ld_if.ld_valid = 1'b0;
    ld_if.ld_last  = 1'b0;
    ld_if.ld_addr  = '0;
    ld_if.ld_data  = '0;
    test_reset();
    test_clear_seed();
    test_load_gaps();
    test_halt();
    test_timeout();
    test_halt_vs_timeout();
    test_back_to_back_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mips_prog_loader.md
# mips_prog_loader

Synthesizable program loader and run supervisor for the pipelined MIPS-32 core. It takes the job the simulation bench does by hand and does it in hardware, so the core can run on silicon and in system-level sims:
- optionally zero-fills instruction/data memory;
- seeds the register file;
- streams a program into memory over a valid/ready port;
- releases the core and counts cycles until the core halts or a timeout expires.

It sits between a host/debug port and the core's memory write port, register-file init port and control pins.

## Interface
- `ADDR_W`, 10, memory word-address width; depth = 2^ADDR_W
- `DATA_W`, 32, memory/register word width
- `NUM_REGS`, 32, register-file entries to seed; `RF_AW` = clog2(NUM_REGS)
- `CNT_W`, 32, cycle counter width
- `CLEAR_EN`, 1, 1 = zero-fill all memory before load; 0 = skip
- `REG_INIT`, 1, 0 = seed register k with 0; 1 = seed register k with k
---
- `clk1`  in  1  single clock, rising edge; one clock, synchronous active-high reset
- `rst`  in  1  synchronous, active-high
- `go`  in  1  start pulse; honoured only in IDLE or DONE
- `ld_valid`  in  1  load word valid
- `ld_ready`  out  1  loader accepts a word
- `ld_addr`  in  ADDR_W  target word address
- `ld_data`  in  DATA_W  word to write
- `ld_last`  in  1  final word of the program
- `mem_we`, `mem_addr`, `mem_wdata`  out  1/ADDR_W/DATA_W  memory write port
- `rf_we`, `rf_addr`, `rf_wdata`  out  1/RF_AW/DATA_W  register-file write port
- `cpu_hold`  out  1  core frozen while high
- `cpu_start`  out  1  one-cycle pulse: core sets PC=0, HALTED=0, TAKEN_BRANCH=0
- `cpu_halted`  in  1  core HALTED flag
- `timeout_cycles`  in  CNT_W  run limit; 0 = unlimited
- `done`, `timed_out`  out  1  run finished / finished by timeout
- `cycle_count`  out  CNT_W  RUN cycles elapsed

## Operation
- **States:** IDLE → CLEAR (if CLEAR_EN) → REGS → LOAD → START → RUN → DONE.
- **DONE** exits on `go` to CLEAR or REGS.
- **IDLE/DONE:** `cpu_hold=1`, no writes.
- **`go`:** clears `done`, `timed_out` and `cycle_count`.
- **CLEAR:** one memory write per cycle, address 0 to 2^ADDR_W−1, data 0. Exits after the last address.
- **REGS:** one register-file write per cycle, address 0 to NUM_REGS−1. Data is 0 or k according to REG_INIT.
- **LOAD:** `ld_ready=1`. Each handshake (`ld_valid & ld_ready`) issues one memory write of `ld_addr`/`ld_data`. A handshake with `ld_last=1` moves the FSM to START. `ld_valid` is ignored in all other states.
- **START:** exactly one cycle. `cpu_start=1`, `cpu_hold=0`, counter cleared.
- **RUN:** `cpu_hold=0`. Priority order each cycle:
  1. `cpu_halted=1` → DONE with `timed_out=0`. Count is not incremented.
  2. Otherwise `cycle_count` increments, saturating at all-ones.
  3. If `timeout_cycles≠0` and the new count equals `timeout_cycles` → DONE with `timed_out=1`.
- **Simultaneous halt and timeout:** halt wins.
- **DONE:** `done=1`, `cpu_hold=1`. `cycle_count` and `timed_out` are frozen.
- **`rst` in any state:** next cycle the FSM is in IDLE and all outputs are at reset values. A load in progress is abandoned.

## Timing
- **Reset values:** `cpu_hold=1`; all other outputs 0.
- `mem_*` and `rf_*` are registered. A write appears one cycle after the handshake or state cycle that generates it. `we` is high for exactly one cycle per word.
- Writes cannot back-pressure; both ports accept one word per cycle.
- `ld_ready` is combinational from state only, never from `ld_valid`.
- **Cycle budget, `go` to first `ld_ready`:** 1 + 2^ADDR_W·CLEAR_EN + NUM_REGS cycles.
- **Last load to `cpu_start`:** the last load handshake is followed by the last `mem_we` and `cpu_start` in the same next cycle.
- `cpu_halted` is registered by the core; the loader samples it directly.

## Structure
- **Shared package `mips_pkg`:**
  - loader state enum;
  - opcode constants HLT=6'b111111, ADD=6'b000000, SUB=6'b000001, ADDI=6'b001010;
  - default ADDR_W/DATA_W.
- **Sub-module `mips_sat_counter`** (parameter CNT_W):
  - inputs: clear, enable;
  - outputs: count, equality flag against a compare input.
- The FSM, address sweep counter and write-port registers stay in the top module.

## Test plan
1. **Clear and seed.** ADDR_W=4, CLEAR_EN=1, REG_INIT=1; pulse `go`.
   - 16 `mem_we` pulses, addresses 0–15, data 0.
   - Then 32 `rf_we` pulses, register k written with k.
   - `ld_ready` rises on cycle 49 after `go`.
2. **Program load with gaps.** Send 0x00430800, 0x2824000A, 0x20232800, 0xFC000000 to addresses 0–3; `ld_valid` low every other cycle; `ld_last` on the 4th word.
   - Four `mem_we` pulses, in order, each one cycle after its handshake.
   - `cpu_start` is high for exactly one cycle, together with the 4th write.
3. **Normal halt.** `cpu_halted` first high on the 8th RUN cycle, `timeout_cycles=100`.
   - `done=1`, `timed_out=0`, `cycle_count=7`, `cpu_hold=1`.
4. **Timeout.** `timeout_cycles=20`, halt never asserted.
   - `done=1`, `timed_out=1`, `cycle_count=20`.
5. **Simultaneous halt and timeout.** `timeout_cycles=20`, halt first high on the 20th RUN cycle.
   - `timed_out=0`, `cycle_count=19`.
6. **Reset mid-load.** Assert `rst` after 2 of 4 words.
   - Next cycle: all outputs at reset values, `cpu_hold=1`, state IDLE.
   - A new `go` restarts the CLEAR sweep at address 0.
